// File: rtl/demux_buf.sv
// 1-to-NOUT valid/ready demux with one output register per channel; 1-cycle accept-to-valid latency, a stalled channel only blocks words aimed at it.
// Optional DEMUX_BROADCAST_EN: in_bcast loads every slot at once when all can accept.
module demux_buf #(
  parameter int WIDTH = 8,
  parameter int NOUT  = 4,
  parameter int SELW  = 2,
  parameter int CNTW  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [WIDTH-1:0]      in_data,
  input  logic [SELW-1:0]       in_sel,
  input  logic                  in_bcast,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [NOUT*WIDTH-1:0] out_data,
  output logic [NOUT-1:0]       out_valid,
  input  logic [NOUT-1:0]       out_ready,
  output logic [CNTW-1:0]       drop_cnt
);

  logic [31:0]     sel_ext;
  logic            sel_ok;
  logic [NOUT-1:0] sel_hit;
  logic [NOUT-1:0] slot_free;
  logic [NOUT-1:0] load;
  logic            route_rdy;
  logic            bcast;
  logic            in_fire;

`ifdef DEMUX_BROADCAST_EN
  assign bcast = in_bcast;
`else
  logic unused_bcast;
  assign unused_bcast = in_bcast;
  assign bcast        = 1'b0;
`endif

  assign sel_ext   = 32'(in_sel);
  assign sel_ok    = sel_ext < 32'(NOUT);
  assign slot_free = ~out_valid | out_ready;

  always_comb begin
    sel_hit = '0;
    for (int k = 0; k < NOUT; k++) begin
      sel_hit[k] = (sel_ext == 32'(k));
    end
  end

  // Out-of-range selects are always accepted so they can be discarded.
  assign route_rdy = sel_ok ? |(sel_hit & slot_free) : 1'b1;
  assign in_ready  = rst_n & (bcast ? &slot_free : route_rdy);
  assign in_fire   = in_valid & in_ready;
  assign load      = {NOUT{in_fire}} & ({NOUT{bcast}} | sel_hit);

  // A slot refilled on the same edge it drains stays full with the new word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= '0;
      out_data  <= '0;
    end else begin
      for (int k = 0; k < NOUT; k++) begin
        if (load[k]) begin
          out_valid[k]               <= 1'b1;
          out_data[k*WIDTH +: WIDTH] <= in_data;
        end else if (out_ready[k]) begin
          out_valid[k] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt <= '0;
    end else if (in_fire && !bcast && !sel_ok && (drop_cnt != {CNTW{1'b1}})) begin
      drop_cnt <= drop_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_demux_buf.sv
// Directed bench for demux_buf: a 4-channel instance for routing and a 3-channel one for drops.
module tb_demux_buf;

  logic        clk;
  logic        rst_n;
  logic [7:0]  in_data;
  logic [1:0]  a_sel;
  logic        a_bcast;
  logic        a_valid;
  logic        a_ready;
  logic [31:0] a_odata;
  logic [3:0]  a_ovalid;
  logic [3:0]  a_oready;
  logic [7:0]  a_drop;

  logic [1:0]  b_sel;
  logic        b_valid;
  logic        b_ready;
  logic [23:0] b_odata;
  logic [2:0]  b_ovalid;
  logic [2:0]  b_oready;
  logic [1:0]  b_drop;

  int checks;
  int failures;

  demux_buf #(.WIDTH(8), .NOUT(4), .SELW(2), .CNTW(8)) u_a (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_sel(a_sel),
    .in_bcast(a_bcast), .in_valid(a_valid), .in_ready(a_ready),
    .out_data(a_odata), .out_valid(a_ovalid), .out_ready(a_oready),
    .drop_cnt(a_drop)
  );

  demux_buf #(.WIDTH(8), .NOUT(3), .SELW(2), .CNTW(2)) u_b (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_sel(b_sel),
    .in_bcast(1'b0), .in_valid(b_valid), .in_ready(b_ready),
    .out_data(b_odata), .out_valid(b_ovalid), .out_ready(b_oready),
    .drop_cnt(b_drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    in_data  = 8'h00;
    a_sel    = 2'd2;
    a_bcast  = 1'b0;
    a_valid  = 1'b1;
    a_oready = 4'b0000;
    b_sel    = 2'd0;
    b_valid  = 1'b0;
    b_oready = 3'b000;

    #2;
    chk("rst_ovalid", 32'(a_ovalid), 32'h0);
    chk("rst_odata", a_odata, 32'h0);
    chk("rst_drop", 32'(a_drop), 32'h0);
    chk("rst_ready", 32'(a_ready), 32'h0);
    #5 rst_n = 1'b1;
    a_valid = 1'b0;
    step();

    // basic route
    in_data = 8'hA5; a_sel = 2'd2; a_valid = 1'b1;
    #1 chk("basic_ready", 32'(a_ready), 32'h1);
    step();
    chk("basic_ovalid", 32'(a_ovalid), 32'h4);
    chk("basic_odata", a_odata, 32'h00A5_0000);

    // back-pressure
    in_data = 8'h3C;
    #1 chk("bp_ready_lo", 32'(a_ready), 32'h0);
    step();
    chk("bp_hold", 32'(a_odata[23:16]), 32'hA5);
    chk("bp_ovalid", 32'(a_ovalid), 32'h4);
    a_oready = 4'b0100;
    #1 chk("bp_ready_hi", 32'(a_ready), 32'h1);
    step();
    chk("bp_refill", 32'(a_odata[23:16]), 32'h3C);
    chk("bp_still_full", 32'(a_ovalid), 32'h4);
    a_valid = 1'b0;
    step();
    chk("bp_drained", 32'(a_ovalid), 32'h0);

    // streaming to channel 1
    a_oready = 4'b0010;
    a_sel    = 2'd1;
    a_valid  = 1'b1;
    for (int i = 0; i < 16; i++) begin
      in_data = 8'(i);
      #1 chk("stream_ready", 32'(a_ready), 32'h1);
      step();
      chk("stream_data", 32'(a_odata[15:8]), 32'(i));
      chk("stream_ovalid", 32'(a_ovalid), 32'h2);
    end
    a_valid = 1'b0;
    step();
    chk("stream_end", 32'(a_ovalid), 32'h0);

    // independence: channel 0 stalled, channel 3 flows
    a_oready = 4'b0000;
    in_data = 8'h77; a_sel = 2'd0; a_valid = 1'b1;
    step();
    chk("ind_ch0_full", 32'(a_ovalid), 32'h1);
    #1 chk("ind_ch0_blocked", 32'(a_ready), 32'h0);
    a_oready = 4'b1000;
    a_sel = 2'd3;
    in_data = 8'h11;
    #1 chk("ind_ch3_ready", 32'(a_ready), 32'h1);
    step();
    chk("ind_ch3_data", 32'(a_odata[31:24]), 32'h11);
    in_data = 8'h22;
    step();
    chk("ind_ch3_data2", 32'(a_odata[31:24]), 32'h22);
    chk("ind_ch0_hold", 32'(a_odata[7:0]), 32'h77);
    chk("ind_ovalid", 32'(a_ovalid), 32'h9);
    a_valid = 1'b0;
    step();
    chk("ind_ch3_drained", 32'(a_ovalid), 32'h1);
    chk("ind_no_drop", 32'(a_drop), 32'h0);

    // drop counter saturates at 3 on the 3-channel instance
    b_sel = 2'd3; b_valid = 1'b1; in_data = 8'hEE;
    for (int i = 1; i <= 5; i++) begin
      #1 chk("drop_ready", 32'(b_ready), 32'h1);
      step();
      chk("drop_cnt", 32'(b_drop), (i < 3) ? 32'(i) : 32'h3);
      chk("drop_ovalid", 32'(b_ovalid), 32'h0);
    end
    b_sel = 2'd2;
    step();
    b_valid = 1'b0;
    chk("drop_route", 32'(b_ovalid), 32'h4);
    chk("drop_route_data", 32'(b_odata[23:16]), 32'hEE);
    chk("drop_unchanged", 32'(b_drop), 32'h3);

    // broadcast against a stalled channel 1
    in_data = 8'h55; a_sel = 2'd1; a_valid = 1'b1;
    step();
    chk("bc_ch1_full", 32'(a_ovalid), 32'h3);
    in_data  = 8'h99;
    a_bcast  = 1'b1;
    a_oready = 4'b0001;
    #1 chk("bc_ready_lo", 32'(a_ready), 32'h0);
    a_oready = 4'b0011;
    #1 chk("bc_ready_hi", 32'(a_ready), 32'h1);
    step();
`ifdef DEMUX_BROADCAST_EN
    chk("bc_ovalid", 32'(a_ovalid), 32'hF);
    chk("bc_odata", a_odata, 32'h9999_9999);
`else
    chk("bc_ovalid", 32'(a_ovalid), 32'h2);
    chk("bc_odata", 32'(a_odata[15:8]), 32'h99);
`endif
    chk("bc_no_drop", 32'(a_drop), 32'h0);

    // asynchronous reset mid-cycle
    a_bcast  = 1'b0;
    a_oready = 4'b0000;
    a_sel    = 2'd0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_ovalid", 32'(a_ovalid), 32'h0);
    chk("arst_odata", a_odata, 32'h0);
    chk("arst_ready", 32'(a_ready), 32'h0);
    chk("arst_drop", 32'(b_drop), 32'h0);
    chk("arst_b_ovalid", 32'(b_ovalid), 32'h0);
    a_valid = 1'b0;
    #3 rst_n = 1'b1;
    step();
    chk("post_rst_ovalid", 32'(a_ovalid), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
